instruction_fetch: RTL

Fetch stage of the PIC16F core, directly downstream of `program_counter`. It runs the four-phase Q1–Q4 instruction-cycle sequencer and issues the program-memory read for the current `pc_out`. It pulses `incr_pc_en` back to the counter and delivers the fetched 14-bit word to execute through the instruction register (IR). This gives the core its two-stage fetch/execute pipeline; `flush_req` replaces the wrongly prefetched word with a NOP after a taken branch or a PCL write.

---
 rtl/pic_pkg.sv | 25 ++
 rtl/q_sequencer.sv | 37 +++
 rtl/instruction_fetch.sv | 101 ++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: phase encodings, widths and helpers shared by the PIC16F front end.
// The fetch stage and its Q-phase sequencer both import this package.
package pic_pkg;

  localparam int PROG_AW = 13;
  localparam int INSN_W  = 14;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } q_phase_t;

  localparam logic [INSN_W-1:0] INSN_NOP = 14'h0000;

  function automatic q_phase_t next_phase(input q_phase_t p);
    return q_phase_t'(p + 2'd1);
  endfunction

  function automatic logic [3:0] phase_onehot(input q_phase_t p);
    return 4'b0001 << p;
  endfunction

endpackage

// File: rtl/q_sequencer.sv
// q_sequencer: four-phase Q1..Q4 instruction-cycle counter.
// Holds while stalled; strobes are registered alongside the phase.
module q_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_i,
  output q_phase_t   phase_o,
  output logic [3:0] strobe_o
);

  q_phase_t   phase_q;
  q_phase_t   phase_d;
  logic [3:0] strobe_q;

  always_comb begin
    phase_d = phase_q;
    if (!stall_i) begin
      phase_d = next_phase(phase_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= Q1;
      strobe_q <= phase_onehot(Q1);
    end else begin
      phase_q  <= phase_d;
      strobe_q <= phase_onehot(phase_d);
    end
  end

  assign phase_o  = phase_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: Q-phase fetch stage feeding the IR of the PIC16F core.
// Prefetches one word per instruction cycle; a flush turns the next IR load into a NOP.
module instruction_fetch #(
  parameter int PROG_AW = pic_pkg::PROG_AW,
  parameter int INSN_W  = pic_pkg::INSN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PROG_AW-1:0] pc_in,
  output logic               incr_pc_en,
  output logic [PROG_AW-1:0] prog_addr,
  output logic               prog_en,
  input  logic [INSN_W-1:0]  prog_data,
  input  logic               stall,
  input  logic               flush_req,
  output logic [1:0]         q_phase,
  output logic [INSN_W-1:0]  ir_out,
  output logic               ir_valid
);

  import pic_pkg::*;

  q_phase_t          phase;
  logic [3:0]        strobe;
  logic              run;
  logic              rd_en;
  logic              cap_en;
  logic              ld_en;
  logic              kill;
  logic [INSN_W-1:0] fbuf_q;
  logic [INSN_W-1:0] fbuf_d;
  logic [INSN_W-1:0] ir_q;
  logic [INSN_W-1:0] ir_d;
  logic              ir_valid_q;
  logic              ir_valid_d;
  logic              flush_q;
  logic              flush_d;

  q_sequencer u_seq (
    .clk      (clk),
    .rst      (rst),
    .stall_i  (stall),
    .phase_o  (phase),
    .strobe_o (strobe)
  );

  always_comb begin
    rd_en  = 1'b0;
    cap_en = 1'b0;
    ld_en  = 1'b0;
    unique case (1'b1)
      strobe[0]: rd_en  = 1'b1;
      strobe[1]: cap_en = 1'b1;
      strobe[2]: ;
      strobe[3]: ld_en  = 1'b1;
      default:   ;
    endcase
  end

  assign run        = !stall && !rst;
  assign prog_addr  = pc_in;
  assign prog_en    = rd_en && run;
  assign incr_pc_en = cap_en && run;
  assign q_phase    = phase;

  // A flush arriving on the load edge itself still kills that load.
  assign kill = flush_q || flush_req;

  always_comb begin
    fbuf_d     = fbuf_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    flush_d    = kill;
    if (cap_en && !stall) begin
      fbuf_d = prog_data;
    end
    if (ld_en && !stall) begin
      ir_d       = kill ? INSN_W'(INSN_NOP) : fbuf_q;
      ir_valid_d = !kill;
      flush_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fbuf_q     <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      fbuf_q     <= fbuf_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      flush_q    <= flush_d;
    end
  end

  assign ir_out   = ir_q;
  assign ir_valid = ir_valid_q;

endmodule
